// File: rtl/ov5640_sccb_master.sv
// SCCB (I2C-compatible) write master for OV5640 register programming.
// One cfg_start pulse produces one 3-phase write: DEVICE_ID, addr[15:8], addr[7:0], val.
// Ports: sys_clk/sys_rst (async, active-high); cfg_start/cfg_data in; cfg_end, busy, ack_err out;
//        sccb_scl, sccb_sda_out, sccb_sda_oe out; sccb_sda_in in (pad SDA = oe ? out : Z).
module ov5640_sccb_master #(
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCCB_FREQ    = 250_000,
  parameter logic [7:0] DEVICE_ID    = 8'h78
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cfg_start,
  input  logic [23:0] cfg_data,
  output logic        cfg_end,
  output logic        busy,
  output logic        ack_err,
  output logic        sccb_scl,
  output logic        sccb_sda_out,
  output logic        sccb_sda_oe,
  input  logic        sccb_sda_in
);

  // Quarter-SCL period in sys_clk cycles.
  localparam int DIV = SYS_CLK_FREQ / (4 * SCCB_FREQ);
  localparam int DW  = $clog2((DIV < 2) ? 2 : DIV);

  generate
    if (DIV < 2) begin : g_div_check
      $error("ov5640_sccb_master: SYS_CLK_FREQ/(4*SCCB_FREQ) must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;

  state_t        state, nxt_state;
  logic [DW-1:0] div_cnt;
  logic [1:0]    phase, nxt_phase;
  logic [5:0]    bit_cnt, nxt_bit_cnt;     // 0..35 across the whole transaction
  logic [3:0]    byte_bit, nxt_byte_bit;   // 0..7 data bits, 8 = ACK slot
  logic [31:0]   shreg, nxt_shreg;         // MSB is the next data bit on the wire
  logic          tick;
  logic          nxt_scl, nxt_oe, nxt_out;

  // Next-state logic. Counters only move on a quarter tick, so every bus edge
  // lines up with a tick boundary.
  always_comb begin
    tick         = (state != S_IDLE) && (state != S_DONE) && (div_cnt == DW'(DIV - 1));
    nxt_state    = state;
    nxt_phase    = phase;
    nxt_bit_cnt  = bit_cnt;
    nxt_byte_bit = byte_bit;
    nxt_shreg    = shreg;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          nxt_state    = S_START;
          nxt_phase    = 2'd0;
          nxt_bit_cnt  = 6'd0;
          nxt_byte_bit = 4'd0;
          nxt_shreg    = {DEVICE_ID, cfg_data};
        end
      end
      S_START: begin
        if (tick) begin
          nxt_phase = phase + 2'd1;
          if (phase == 2'd3) nxt_state = S_BIT;
        end
      end
      S_BIT: begin
        if (tick) begin
          nxt_phase = phase + 2'd1;
          if (phase == 2'd3) begin
            // ACK slots consume no data, so the shifter only advances on data slots.
            if (byte_bit != 4'd8) nxt_shreg = {shreg[30:0], 1'b0};
            nxt_byte_bit = (byte_bit == 4'd8) ? 4'd0 : byte_bit + 4'd1;
            if (bit_cnt == 6'd35) nxt_state = S_STOP;
            else nxt_bit_cnt = bit_cnt + 6'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          nxt_phase = phase + 2'd1;
          if (phase == 2'd3) nxt_state = S_DONE;
        end
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Bus levels for the upcoming state/phase; registered below so the pins
  // change on the same edge the phase does.
  always_comb begin
    nxt_scl = 1'b1;
    nxt_oe  = 1'b0;
    nxt_out = 1'b1;
    case (nxt_state)
      S_START: begin
        nxt_oe  = 1'b1;
        nxt_out = (nxt_phase == 2'd0);
        nxt_scl = ~nxt_phase[1];
      end
      S_BIT: begin
        nxt_scl = (nxt_phase == 2'd1) || (nxt_phase == 2'd2);
        if (nxt_byte_bit != 4'd8) begin
          nxt_oe  = 1'b1;
          nxt_out = nxt_shreg[31];
        end
      end
      S_STOP: begin
        nxt_oe  = 1'b1;
        nxt_scl = (nxt_phase != 2'd0);
        nxt_out = nxt_phase[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      phase        <= 2'd0;
      bit_cnt      <= 6'd0;
      byte_bit     <= 4'd0;
      shreg        <= 32'd0;
      sccb_scl     <= 1'b1;
      sccb_sda_oe  <= 1'b0;
      sccb_sda_out <= 1'b1;
      cfg_end      <= 1'b0;
      busy         <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      state        <= nxt_state;
      phase        <= nxt_phase;
      bit_cnt      <= nxt_bit_cnt;
      byte_bit     <= nxt_byte_bit;
      shreg        <= nxt_shreg;
      div_cnt      <= (state == S_IDLE || state == S_DONE || tick) ? '0 : div_cnt + DW'(1);
      sccb_scl     <= nxt_scl;
      sccb_sda_oe  <= nxt_oe;
      sccb_sda_out <= nxt_out;
      cfg_end      <= (nxt_state == S_DONE);
      busy         <= (nxt_state != S_IDLE);
      // Sample the ACK at the end of the SCL-high window (p2); a NACK is only
      // recorded, the transaction always runs to STOP.
      if (state == S_IDLE && cfg_start)
        ack_err <= 1'b0;
      else if (state == S_BIT && tick && phase == 2'd2 && byte_bit == 4'd8 && sccb_sda_in)
        ack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ov5640_sccb_master.sv
// Self-checking bench for ov5640_sccb_master with DIV = 4.
// An I2C slave model on the bus decodes bytes, checks START/STOP placement and drives ACK/NACK.
module tb_ov5640_sccb_master;

  localparam int         DIV     = 4;
  localparam int         TXN_CYC = 152 * DIV + 1;
  localparam logic [7:0] DEV     = 8'h78;

  logic        sys_clk   = 1'b0;
  logic        sys_rst   = 1'b1;
  logic        cfg_start = 1'b0;
  logic [23:0] cfg_data  = 24'd0;
  logic        cfg_end, busy, ack_err, sccb_scl, sccb_sda_out, sccb_sda_oe, sccb_sda_in;
  logic        slave_low = 1'b0;

  // Open-drain bus with pull-up: released SDA reads 1 unless the slave pulls it low.
  assign sccb_sda_in = sccb_sda_oe ? sccb_sda_out : ~slave_low;

  ov5640_sccb_master #(
    .SYS_CLK_FREQ(4_000_000),
    .SCCB_FREQ   (250_000),
    .DEVICE_ID   (DEV)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cfg_start   (cfg_start),
    .cfg_data    (cfg_data),
    .cfg_end     (cfg_end),
    .busy        (busy),
    .ack_err     (ack_err),
    .sccb_scl    (sccb_scl),
    .sccb_sda_out(sccb_sda_out),
    .sccb_sda_oe (sccb_sda_oe),
    .sccb_sda_in (sccb_sda_in)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor / slave model ----------------
  int         start_edge    = -1000000;
  logic [3:0] nack_mask     = 4'd0;
  int         end_cnt       = 0;
  int         end_cyc       = 0;
  int         stop_cnt      = 0;
  int         proto_err     = 0;
  int         busy_bad      = 0;
  int         first_ack_cyc = -1;
  logic       ack_at1       = 1'b0;
  logic       scl_at0       = 1'b0;
  logic [7:0] got[$];
  int         sl_bits       = 0;
  logic       sl_active     = 1'b0;
  logic [7:0] sr            = 8'd0;
  logic       scl_p         = 1'b1;
  logic       sda_p         = 1'b1;
  int         c;
  logic       sda_n;

  always @(negedge sys_clk) begin
    c     = cyc - start_edge + 1;
    sda_n = sccb_sda_in;
    if (sys_rst) begin
      sl_active = 1'b0;
      sl_bits   = 0;
      slave_low = 1'b0;
    end else begin
      if (cfg_end === 1'b1) begin
        end_cnt++;
        end_cyc = c;
      end
      if (c >= 0 && c <= TXN_CYC + 3 && busy !== (c >= 1 && c <= TXN_CYC)) busy_bad++;
      if (c == 0) begin
        first_ack_cyc = -1;
        scl_at0       = sccb_scl;
      end
      if (c == 1) ack_at1 = ack_err;
      if (c >= 1 && ack_err === 1'b1 && first_ack_cyc < 0) first_ack_cyc = c;
      if (scl_p && sccb_scl && sda_p !== sda_n) begin
        // SDA moved while SCL high: only legal as START (idle bus) or STOP (after 36 bits).
        if (!sda_n) begin
          if (sl_active) proto_err++;
          sl_active = 1'b1;
          sl_bits   = 0;
        end else begin
          if (!sl_active || sl_bits != 36) proto_err++;
          sl_active = 1'b0;
          stop_cnt++;
        end
      end else if (!scl_p && sccb_scl && sl_active && sl_bits < 36) begin
        sl_bits++;
        if (sl_bits % 9 != 0) begin
          sr = {sr[6:0], sda_n};
          if (sl_bits % 9 == 8) got.push_back(sr);
        end
      end else if (scl_p && !sccb_scl && sl_active) begin
        slave_low = (sl_bits % 9 == 8) && !nack_mask[sl_bits / 9];
      end
    end
    scl_p = sccb_scl;
    sda_p = sda_n;
  end

  // ---------------- reference model ----------------
  function automatic int exp_first_ack(input logic [3:0] m);
    // ACK slot of byte k is slot 9k+8; its p2 ends on tick 4 + 4*slot + 3.
    for (int k = 0; k < 4; k++)
      if (m[k]) return DIV * (4 + 4 * (9 * k + 8) + 3) + 1;
    return -1;
  endfunction

  typedef struct {
    logic [23:0] data;
    logic [3:0]  nack;
    logic [31:0] bytes;
    logic        err;
    int          first_ack;
  } vec_t;

  vec_t tbl[8];

  // ---------------- stimulus helpers ----------------
  int b_end, b_stop, b_proto, b_busy, b_got;

  task automatic launch(input logic [23:0] d, input logic [3:0] m);
    b_end     = end_cnt;
    b_stop    = stop_cnt;
    b_proto   = proto_err;
    b_busy    = busy_bad;
    b_got     = got.size();
    nack_mask = m;
    cfg_data  = d;
    cfg_start = 1'b1;
    start_edge = cyc + 1;
    @(posedge sys_clk);
    #1 cfg_start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TXN_CYC + 50; i++) begin
      @(negedge sys_clk);
      if (cfg_end === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic finish_checks(input string tag, input logic [31:0] eb, input logic ee,
                               input int efa);
    bit          ok;
    logic [31:0] gb;
    wait_end(ok);
    check({tag, " completes"}, ok, 1);
    repeat (4) @(negedge sys_clk);
    #1;
    check({tag, " cfg_end pulses"}, end_cnt - b_end, 1);
    if (ok) check({tag, " cfg_end cycle"}, end_cyc, TXN_CYC);
    check({tag, " byte count"}, got.size() - b_got, 4);
    gb = 32'd0;
    if (got.size() - b_got == 4)
      gb = {got[b_got], got[b_got+1], got[b_got+2], got[b_got+3]};
    check({tag, " bytes"}, gb, eb);
    check({tag, " ack_err"}, ack_err, ee);
    check({tag, " ack_err set cycle"}, first_ack_cyc, efa);
    check({tag, " ack_err cleared on start"}, ack_at1, 1'b0);
    check({tag, " busy window"}, busy_bad - b_busy, 0);
    check({tag, " stop count"}, stop_cnt - b_stop, 1);
    check({tag, " protocol"}, proto_err - b_proto, 0);
    check({tag, " busy idle"}, busy, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;

    tbl[0] = '{24'h300882, 4'b0000, 32'h78300882, 1'b0, -1};
    tbl[1] = '{24'h300882, 4'b0100, 32'h78300882, 1'b1, 445};
    tbl[2] = '{24'h123456, 4'b0001, 32'h78123456, 1'b1, 157};
    for (int i = 3; i < 8; i++) begin
      tbl[i].data = 24'($urandom);
      for (int k = 0; k < 4; k++) tbl[i].nack[k] = ($urandom_range(0, 3) == 0);
      tbl[i].bytes     = {DEV, tbl[i].data};
      tbl[i].err       = |tbl[i].nack;
      tbl[i].first_ack = exp_first_ack(tbl[i].nack);
    end

    // Reset values
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset scl", sccb_scl, 1'b1);
    check("reset sda_oe", sccb_sda_oe, 1'b0);
    check("reset sda_out", sccb_sda_out, 1'b1);
    check("reset cfg_end", cfg_end, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset ack_err", ack_err, 1'b0);
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);

    // Table-driven writes
    for (int i = 0; i < 8; i++) begin
      @(posedge sys_clk);
      #1 launch(tbl[i].data, tbl[i].nack);
      finish_checks($sformatf("vec%0d", i), tbl[i].bytes, tbl[i].err, tbl[i].first_ack);
    end

    // Busy ignore: second request mid-transaction and cfg_data changed afterwards
    @(posedge sys_clk);
    #1 launch(24'h300882, 4'b0000);
    repeat (98) @(posedge sys_clk);
    #1;
    cfg_data  = 24'h3017ff;
    cfg_start = 1'b1;
    @(posedge sys_clk);
    #1 cfg_start = 1'b0;
    finish_checks("busy_ignore", 32'h78300882, 1'b0, -1);

    // Back-to-back: new request registered off cfg_end
    @(posedge sys_clk);
    #1 launch(24'h300882, 4'b0000);
    wait_end(ok);
    #1;
    check("b2b first completes", ok, 1);
    check("b2b first cfg_end cycle", end_cyc, TXN_CYC);
    check("b2b first byte count", got.size() - b_got, 4);
    @(posedge sys_clk);
    #1 launch(24'h503d80, 4'b0000);
    check("b2b idle gap scl", scl_at0, 1'b1);
    finish_checks("b2b second", 32'h78503d80, 1'b0, -1);

    // Reset in the middle of BIT slot 12
    @(posedge sys_clk);
    #1 launch(24'h300882, 4'b0000);
    repeat (208) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    #1;
    check("midrst scl", sccb_scl, 1'b1);
    check("midrst sda_oe", sccb_sda_oe, 1'b0);
    check("midrst busy", busy, 1'b0);
    check("midrst cfg_end", cfg_end, 1'b0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (TXN_CYC) @(negedge sys_clk);
    #1;
    check("midrst no cfg_end", end_cnt - b_end, 0);
    @(posedge sys_clk);
    #1 launch(tbl[1].data, tbl[1].nack);
    finish_checks("after_rst", tbl[1].bytes, tbl[1].err, tbl[1].first_ack);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
